// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) against a one-entry held long-latency
// result (B), with a starvation bound and a pending-write scoreboard. WB_ARB_STATS_EN adds counters.
module wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_stall,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] q_raddr1,
    input  logic [ADDR_W-1:0] q_raddr2,
    output logic              q_busy1,
    output logic              q_busy2,
`ifdef WB_ARB_STATS_EN
    output logic [31:0]       stat_stall_cycles,
    output logic [31:0]       stat_b_writes,
`endif
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [3:0] MW = 4'(MAX_WAIT);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              hold_v;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [3:0]        wait_cnt;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pend_nxt;
    logic              a_req, preempt, grant_h, accept;
    wr_t               wr;

    assign a_req   = a_we && (a_waddr != '0);
    assign preempt = hold_v && (wait_cnt >= MW);
    assign grant_h = hold_v && (!a_req || preempt);
    assign b_ready = !rst && (!hold_v || grant_h);
    assign accept  = b_valid && b_ready;
    assign a_stall = !rst && a_req && grant_h;

    // The regfile forwards the write in the same cycle, so the interlock drops in the write cycle.
    assign q_busy1 = !rst && pending[q_raddr1] && !(grant_h && hold_addr == q_raddr1);
    assign q_busy2 = !rst && pending[q_raddr2] && !(grant_h && hold_addr == q_raddr2);

    always_comb begin
        wr = '0;
        if (!rst) begin
            if (grant_h)    wr = '{we: 1'b1, addr: hold_addr, data: hold_data};
            else if (a_req) wr = '{we: 1'b1, addr: a_waddr,   data: a_wdata};
        end
    end

    assign rf_we    = wr.we;
    assign rf_waddr = wr.addr;
    assign rf_wdata = wr.data;

    // Set after clear so a re-issue in the drain cycle keeps the bit.
    always_comb begin
        pend_nxt = pending;
        if (grant_h)   pend_nxt[hold_addr] = 1'b0;
        if (iss_valid) pend_nxt[iss_addr]  = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v   <= 1'b0;
            wait_cnt <= '0;
            pending  <= '0;
        end else begin
            if (accept) begin
                hold_v    <= (b_waddr != '0);
                hold_addr <= b_waddr;
                hold_data <= b_wdata;
            end else if (grant_h) begin
                hold_v <= 1'b0;
            end
            if (!hold_v || grant_h)   wait_cnt <= '0;
            else if (wait_cnt != 4'hf) wait_cnt <= wait_cnt + 4'd1;
            pending <= pend_nxt;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_b_writes     <= '0;
        end else begin
            stat_stall_cycles <= stat_stall_cycles + 32'(a_stall);
            stat_b_writes     <= stat_b_writes + 32'(grant_h);
        end
    end
`endif
endmodule
